// File: rtl/dm12_32_bit.sv
// rtl/dm12_32_bit.sv - buffered 1:2 demultiplexer with per-channel FIFO queues
//
// Purpose:
//   Routes one producer word (D, selected by S) into one of two independent
//   FIFO queues.  Each queue has its own valid/ready handshake.  A stalled
//   or full channel never blocks words routed to the other channel.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   D, S, D_VALID       producer word, route select, word-present flag
//   D_READY             combinational accept: the selected queue is not full
//   Y0, Y0_VALID        channel 0 head word (0 when empty), queue non-empty
//   Y0_READY            channel 0 consumer takes the head
//   Y1, Y1_VALID        channel 1 head word (0 when empty), queue non-empty
//   Y1_READY            channel 1 consumer takes the head
//   CNT0, CNT1          16-bit pop counters, present only with DM12_COUNT_EN
//
// Configuration macro: DM12_COUNT_EN adds the CNT0/CNT1 pop counters.

module dm12_32_bit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] D,
  input  logic             S,
  input  logic             D_VALID,
  output logic             D_READY,
  output logic [WIDTH-1:0] Y0,
  output logic             Y0_VALID,
  input  logic             Y0_READY,
  output logic [WIDTH-1:0] Y1,
  output logic             Y1_VALID,
  input  logic             Y1_READY
`ifdef DM12_COUNT_EN
  ,
  output logic [15:0]      CNT0,
  output logic [15:0]      CNT1
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [PW-1:0]    wptr_q [2];
  logic [PW-1:0]    wptr_d [2];
  logic [PW-1:0]    rptr_q [2];
  logic [PW-1:0]    rptr_d [2];
  logic [CW-1:0]    occ_q  [2];
  logic [CW-1:0]    occ_d  [2];

  logic full0, full1, valid0, valid1;
  logic push0, push1, pop0, pop1;

  // Status comes only from registered occupancy, so Yn/Yn_VALID never see D, S or Yn_READY.
  assign full0  = (occ_q[0] == FULL_CNT);
  assign full1  = (occ_q[1] == FULL_CNT);
  assign valid0 = (occ_q[0] != '0);
  assign valid1 = (occ_q[1] != '0);

  // A full queue refuses even if its consumer pops this cycle: no pass-through.
  assign D_READY = S ? !full1 : !full0;

  assign push0 = D_VALID && D_READY && !S;
  assign push1 = D_VALID && D_READY && S;
  assign pop0  = valid0 && Y0_READY;
  assign pop1  = valid1 && Y1_READY;

  // Pointers wrap naturally because DEPTH is a power of two; occupancy
  // distinguishes full from empty when the pointers are equal.
  always_comb begin
    wptr_d[0] = push0 ? wptr_q[0] + PW'(1) : wptr_q[0];
    wptr_d[1] = push1 ? wptr_q[1] + PW'(1) : wptr_q[1];
    rptr_d[0] = pop0  ? rptr_q[0] + PW'(1) : rptr_q[0];
    rptr_d[1] = pop1  ? rptr_q[1] + PW'(1) : rptr_q[1];

    occ_d[0] = occ_q[0];
    unique case ({push0, pop0})
      2'b10:   occ_d[0] = occ_q[0] + CW'(1);
      2'b01:   occ_d[0] = occ_q[0] - CW'(1);
      default: occ_d[0] = occ_q[0];
    endcase

    occ_d[1] = occ_q[1];
    unique case ({push1, pop1})
      2'b10:   occ_d[1] = occ_q[1] + CW'(1);
      2'b01:   occ_d[1] = occ_q[1] - CW'(1);
      default: occ_d[1] = occ_q[1];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        occ_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        occ_q[c]  <= occ_d[c];
      end
    end
  end

  // Storage is not reset; the empty-queue masking below hides stale entries.
  always_ff @(posedge clk) begin
    if (push0) mem_q[0][wptr_q[0]] <= D;
    if (push1) mem_q[1][wptr_q[1]] <= D;
  end

  assign Y0_VALID = valid0;
  assign Y1_VALID = valid1;
  assign Y0       = valid0 ? mem_q[0][rptr_q[0]] : '0;
  assign Y1       = valid1 ? mem_q[1][rptr_q[1]] : '0;

`ifdef DM12_COUNT_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Wraps 0xFFFF -> 0x0000 through natural 16-bit overflow.
  assign cnt0_d = pop0 ? cnt0_q + 16'd1 : cnt0_q;
  assign cnt1_d = pop1 ? cnt1_q + 16'd1 : cnt1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign CNT0 = cnt0_q;
  assign CNT1 = cnt1_q;
`endif

endmodule

// File: tb/tb_dm12_32_bit.sv
// tb/tb_dm12_32_bit.sv - scoreboard testbench for dm12_32_bit

module tb_dm12_32_bit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] D;
  logic        S;
  logic        D_VALID;
  logic        D_READY;
  logic [31:0] Y0, Y1;
  logic        Y0_VALID, Y1_VALID;
  logic        Y0_READY, Y1_READY;
`ifdef DM12_COUNT_EN
  logic [15:0] CNT0, CNT1;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] exp0[$];
  logic [31:0] exp1[$];

  dm12_32_bit #(.WIDTH(32), .DEPTH(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .D        (D),
    .S        (S),
    .D_VALID  (D_VALID),
    .D_READY  (D_READY),
    .Y0       (Y0),
    .Y0_VALID (Y0_VALID),
    .Y0_READY (Y0_READY),
    .Y1       (Y1),
    .Y1_VALID (Y1_VALID),
    .Y1_READY (Y1_READY)
`ifdef DM12_COUNT_EN
    ,
    .CNT0     (CNT0),
    .CNT1     (CNT1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word; the expected value enters the scoreboard once the accept is seen.
  task automatic send(input logic [31:0] d, input logic s);
    int budget;
    D       = d;
    S       = s;
    D_VALID = 1'b1;
    budget  = 0;
    @(negedge clk);
    while (!D_READY && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (D_READY) begin
      if (s) exp1.push_back(d);
      else   exp0.push_back(d);
    end else begin
      check("send_timeout", {31'd0, D_READY}, 32'd1);
    end
    @(posedge clk);
    #1;
    D_VALID = 1'b0;
  endtask

  // Monitor: a handshake visible at the falling edge is the pop at the next rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (Y0_VALID && Y0_READY) begin
        if (exp0.size() == 0) check("y0_unexpected_pop", Y0, 32'hxxxx_xxxx);
        else check("y0_data", Y0, exp0.pop_front());
      end else if (!Y0_VALID) begin
        check("y0_zero_when_empty", Y0, 32'd0);
      end
      if (Y1_VALID && Y1_READY) begin
        if (exp1.size() == 0) check("y1_unexpected_pop", Y1, 32'hxxxx_xxxx);
        else check("y1_data", Y1, exp1.pop_front());
      end else if (!Y1_VALID) begin
        check("y1_zero_when_empty", Y1, 32'd0);
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    D        = '0;
    S        = 1'b0;
    D_VALID  = 1'b0;
    Y0_READY = 1'b0;
    Y1_READY = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_y0_valid", {31'd0, Y0_VALID}, 32'd0);
    check("rst_y1_valid", {31'd0, Y1_VALID}, 32'd0);
    check("rst_y0", Y0, 32'd0);
    check("rst_y1", Y1, 32'd0);
    check("rst_d_ready", {31'd0, D_READY}, 32'd1);
    reset_n = 1'b1;
    tick();

    // Routing and one-cycle latency, no cross-contamination
    send(32'hDEADBEEF, 1'b0);
    check("lat_y0_valid", {31'd0, Y0_VALID}, 32'd1);
    check("lat_y0", Y0, 32'hDEADBEEF);
    check("lat_y1_valid", {31'd0, Y1_VALID}, 32'd0);
    send(32'h12345678, 1'b1);
    check("lat_y1_valid2", {31'd0, Y1_VALID}, 32'd1);
    check("lat_y1", Y1, 32'h12345678);
    check("lat_y0_hold", Y0, 32'hDEADBEEF);
    Y0_READY = 1'b1;
    Y1_READY = 1'b1;
    repeat (3) tick();
    Y0_READY = 1'b0;
    Y1_READY = 1'b0;

    // Full channel 0 refuses even with a same-cycle pop; channel 1 still accepts
    send(32'hA0, 1'b0);
    send(32'hA1, 1'b0);
    D = 32'hA2;
    S = 1'b0;
    D_VALID  = 1'b1;
    Y0_READY = 1'b1;
    #1;
    check("full_d_ready_s0", {31'd0, D_READY}, 32'd0);
    D_VALID = 1'b0;
    S = 1'b1;
    #1;
    check("full_d_ready_s1", {31'd0, D_READY}, 32'd1);
    Y0_READY = 1'b0;
    send(32'hB0, 1'b1);
    check("b0_y1", Y1, 32'hB0);
    Y0_READY = 1'b1;
    Y1_READY = 1'b1;
    repeat (4) tick();
    Y0_READY = 1'b0;
    Y1_READY = 1'b0;
    check("drain_q0", exp0.size(), 32'd0);
    check("drain_q1", exp1.size(), 32'd0);

    // Ordering under toggling backpressure
    fork
      begin
        for (int i = 1; i <= 8; i++) send(i, 1'b0);
      end
      begin
        for (int k = 0; k < 30; k++) begin
          Y0_READY = ~Y0_READY;
          tick();
        end
      end
    join
    Y0_READY = 1'b1;
    repeat (4) tick();
    Y0_READY = 1'b0;
    check("order_q0_empty", exp0.size(), 32'd0);
    check("order_y0_valid", {31'd0, Y0_VALID}, 32'd0);

    // Simultaneous push and pop at occupancy 1 on channel 1
    send(32'h11, 1'b1);
    Y1_READY = 1'b1;
    send(32'h22, 1'b1);
    check("pp_y1_valid", {31'd0, Y1_VALID}, 32'd1);
    check("pp_y1_head", Y1, 32'h22);
    tick();
    check("pp_y1_empty", {31'd0, Y1_VALID}, 32'd0);
    Y1_READY = 1'b0;

    // Asynchronous reset with two words queued on channel 0
    send(32'h55, 1'b0);
    send(32'h66, 1'b0);
    check("pre_rst_y0", Y0, 32'h55);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_y0_valid", {31'd0, Y0_VALID}, 32'd0);
    check("async_rst_y0", Y0, 32'd0);
    exp0.delete();
    exp1.delete();
    tick();
    reset_n = 1'b1;
    S = 1'b0;
    #1;
    check("post_rst_ready_s0", {31'd0, D_READY}, 32'd1);
    S = 1'b1;
    #1;
    check("post_rst_ready_s1", {31'd0, D_READY}, 32'd1);
    tick();

`ifdef DM12_COUNT_EN
    // Pop counters: 5 on channel 0, 3 on channel 1, then wrap channel 0
    Y0_READY = 1'b1;
    Y1_READY = 1'b1;
    for (int i = 0; i < 5; i++) send(32'h100 + i, 1'b0);
    for (int i = 0; i < 3; i++) send(32'h200 + i, 1'b1);
    repeat (3) tick();
    check("cnt0_5", {16'd0, CNT0}, 32'd5);
    check("cnt1_3", {16'd0, CNT1}, 32'd3);
    for (int i = 0; i < 65531; i++) send(i, 1'b0);
    repeat (3) tick();
    check("cnt0_wrap", {16'd0, CNT0}, 32'd0);
    check("cnt1_hold", {16'd0, CNT1}, 32'd3);
    Y0_READY = 1'b0;
    Y1_READY = 1'b0;
`endif

    check("final_q0_empty", exp0.size(), 32'd0);
    check("final_q1_empty", exp1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
